// File: rtl/sseg_scanner.sv
// Time-multiplexed seven-segment scanner with tear-free frame-aligned updates.
// Drives active-low anode, segment and decimal-point pins from a shadow copy of the value.
module sseg_scanner #(
   parameter int DIGITS   = 8,
   parameter int PRESCALE = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic                  blank_lz,
   input  logic                  load,
   output logic [6:0]            sseg,
   output logic                  DP,
   output logic [DIGITS-1:0]     AN,
   output logic                  frame_done,
   output logic                  pending
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(PRESCALE);

   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic [4*DIGITS-1:0]   r_stage_val;
   logic [DIGITS-1:0]     r_stage_dp;
   logic [4*DIGITS-1:0]   r_shadow_val;
   logic [DIGITS-1:0]     r_shadow_dp;
   logic                  r_pending;
   logic [6:0]            r_sseg;
   logic                  r_dp;
   logic [DIGITS-1:0]     r_an;
   logic                  r_frame_done;

   logic                  w_tick;
   logic                  w_boundary;
   logic [DIGITS-1:0]     w_zero_sfx;
   logic [3:0]            w_nib;
   logic                  w_dp_req;
   logic                  w_en;
   logic                  w_lz;
   logic [DIGITS-1:0]     w_an_sel;
   logic                  w_blank;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0:    hex7 = 7'h40;
         4'h1:    hex7 = 7'h79;
         4'h2:    hex7 = 7'h24;
         4'h3:    hex7 = 7'h30;
         4'h4:    hex7 = 7'h19;
         4'h5:    hex7 = 7'h12;
         4'h6:    hex7 = 7'h02;
         4'h7:    hex7 = 7'h78;
         4'h8:    hex7 = 7'h00;
         4'h9:    hex7 = 7'h10;
         4'hA:    hex7 = 7'h08;
         4'hB:    hex7 = 7'h03;
         4'hC:    hex7 = 7'h46;
         4'hD:    hex7 = 7'h21;
         4'hE:    hex7 = 7'h06;
         4'hF:    hex7 = 7'h0E;
         default: hex7 = 7'h7F;
      endcase
   endfunction

   assign w_tick     = (r_cnt == CW'(PRESCALE - 1));
   assign w_boundary = w_tick && (r_idx == IW'(DIGITS - 1));

   // Prescaler, digit index, staging and shadow registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt        <= {CW{1'b0}};
         r_idx        <= {IW{1'b0}};
         r_stage_val  <= {(4*DIGITS){1'b0}};
         r_stage_dp   <= {DIGITS{1'b0}};
         r_shadow_val <= {(4*DIGITS){1'b0}};
         r_shadow_dp  <= {DIGITS{1'b0}};
         r_pending    <= 1'b0;
      end else begin
         r_cnt <= w_tick ? {CW{1'b0}} : r_cnt + CW'(1);
         if (w_tick) begin
            r_idx <= (r_idx == IW'(DIGITS - 1)) ? {IW{1'b0}} : r_idx + IW'(1);
         end
         if (load) begin
            r_stage_val <= value;
            r_stage_dp  <= dp_in;
         end
         // A same-cycle load bypasses staging so the freshest value wins the boundary.
         if (w_boundary) begin
            if (load) begin
               r_shadow_val <= value;
               r_shadow_dp  <= dp_in;
            end else if (r_pending) begin
               r_shadow_val <= r_stage_val;
               r_shadow_dp  <= r_stage_dp;
            end
            r_pending <= 1'b0;
         end else if (load) begin
            r_pending <= 1'b1;
         end
      end
   end

   // Per digit: are this nibble and every more-significant nibble zero?
   always_comb begin
      w_zero_sfx = {DIGITS{1'b1}};
      for (int i = 0; i < DIGITS; i++) begin
         for (int j = 0; j < DIGITS; j++) begin
            w_zero_sfx[i] = w_zero_sfx[i] & ((j < i) || (r_shadow_val[4*j +: 4] == 4'h0));
         end
      end
   end

   // Select the current digit's nibble, dp, enable and anode, then apply the blank rule.
   always_comb begin
      w_nib    = 4'h0;
      w_dp_req = 1'b0;
      w_en     = 1'b0;
      w_lz     = 1'b0;
      w_an_sel = {DIGITS{1'b1}};
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_nib       = r_shadow_val[4*i +: 4];
            w_dp_req    = r_shadow_dp[i];
            w_en        = digit_en[i];
            w_lz        = w_zero_sfx[i];
            w_an_sel[i] = 1'b0;
         end else begin
            w_an_sel[i] = 1'b1;
         end
      end
      w_blank = !w_en || (blank_lz && (r_idx != {IW{1'b0}}) && w_lz);
   end

   // Registered pin drivers, one cycle behind index/shadow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_an         <= {DIGITS{1'b1}};
         r_sseg       <= 7'h7F;
         r_dp         <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_boundary;
         if (w_blank) begin
            r_an   <= {DIGITS{1'b1}};
            r_sseg <= 7'h7F;
            r_dp   <= 1'b1;
         end else begin
            r_an   <= w_an_sel;
            r_sseg <= hex7(w_nib);
            r_dp   <= ~w_dp_req;
         end
      end
   end

   assign sseg       = r_sseg;
   assign DP         = r_dp;
   assign AN         = r_an;
   assign frame_done = r_frame_done;
   assign pending    = r_pending;

endmodule

// File: tb/tb_sseg_scanner.sv
// Scoreboard bench for sseg_scanner: a time-based reference model queues the expected
// pin state for every clock edge and a monitor compares the DUT against it.
module tb_sseg_scanner;

   localparam int D = 8;
   localparam int P = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   value = 32'h0;
   logic [7:0]    dp_in = 8'h0;
   logic [7:0]    digit_en = 8'hFF;
   logic          blank_lz = 1'b0;
   logic          load = 1'b0;
   logic [6:0]    sseg;
   logic          DP;
   logic [7:0]    AN;
   logic          frame_done;
   logic          pending;

   sseg_scanner #(.DIGITS(D), .PRESCALE(P)) dut (
      .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_en(digit_en),
      .blank_lz(blank_lz), .load(load), .sseg(sseg), .DP(DP), .AN(AN),
      .frame_done(frame_done), .pending(pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] sseg;
      logic       dp;
      logic       fd;
      logic       pend;
   } exp_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model state: cycles since reset release plus shown/staged values.
   int          m_t = 0;
   logic [31:0] m_shadow = 32'h0, m_stage = 32'h0;
   logic [7:0]  m_sdp = 8'h0, m_stage_dp = 8'h0;
   logic        m_pending = 1'b0;

   function automatic int cur_idx();
      return (m_t / P) % D;
   endfunction

   function automatic bit next_is_boundary();
      return !reset && (m_t % P == P - 1) && (cur_idx() == D - 1);
   endfunction

   task automatic model_step();
      exp_t e;
      int   idx;
      bit   blank, bnd;
      logic [31:0] upper;
      if (reset) begin
         e = '{an: 8'hFF, sseg: 7'h7F, dp: 1'b1, fd: 1'b0, pend: 1'b0};
         m_t = 0; m_shadow = 32'h0; m_stage = 32'h0; m_sdp = 8'h0; m_stage_dp = 8'h0;
         m_pending = 1'b0;
      end else begin
         idx   = cur_idx();
         upper = m_shadow >> (4 * idx);
         blank = !digit_en[idx] || (blank_lz && idx > 0 && upper == 32'h0);
         if (blank) begin
            e.an = 8'hFF; e.sseg = 7'h7F; e.dp = 1'b1;
         end else begin
            e.an = ~(8'h01 << idx); e.sseg = hex_tab[upper[3:0]]; e.dp = ~m_sdp[idx];
         end
         bnd = (m_t % P == P - 1) && (idx == D - 1);
         if (bnd) begin
            if (load) begin
               m_shadow = value; m_sdp = dp_in;
            end else if (m_pending) begin
               m_shadow = m_stage; m_sdp = m_stage_dp;
            end
            m_pending = 1'b0;
         end else if (load) begin
            m_pending = 1'b1;
         end
         if (load) begin
            m_stage = value; m_stage_dp = dp_in;
         end
         e.fd = bnd; e.pend = m_pending;
         m_t++;
      end
      q.push_back(e);
   endtask

   // One clock: current inputs are modelled, then sampled at the coming rising edge.
   task automatic tick_cyc(input logic ld);
      load = ld;
      model_step();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick_cyc(1'b0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: every rising edge yields one pin state, compared against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("AN", 32'(AN), 32'(e.an));
            chk("sseg", 32'(sseg), 32'(e.sseg));
            chk("DP", 32'(DP), 32'(e.dp));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
            chk("pending", 32'(pending), 32'(e.pend));
            chk("an_overlap", 32'($countones(~AN) <= 1), 32'd1);
         end
      end
   end

   initial begin
      reset = 1'b1;
      run(3);
      reset = 1'b0;
      run(40);

      value = 32'h89ABCDEF;
      tick_cyc(1'b1);
      run(70);

      run(10);
      value = 32'h11111111;
      tick_cyc(1'b1);
      run(60);

      value = 32'h00000002;
      if (next_is_boundary()) run(1);
      tick_cyc(1'b1);
      for (int k = 0; k < 100 && !next_is_boundary(); k++) tick_cyc(1'b0);
      value = 32'hDEADBEEF;
      tick_cyc(1'b1);
      run(40);

      blank_lz = 1'b1; value = 32'h00000305; dp_in = 8'h04;
      tick_cyc(1'b1);
      run(70);
      value = 32'h0; dp_in = 8'h0;
      tick_cyc(1'b1);
      run(70);
      value = 32'h00000305; digit_en = 8'hFD;
      tick_cyc(1'b1);
      run(70);
      digit_en = 8'hFF; blank_lz = 1'b0;

      for (int k = 0; k < 100 && cur_idx() != 2; k++) tick_cyc(1'b0);
      value = 32'hCAFE1234;
      tick_cyc(1'b1);
      for (int k = 0; k < 100 && cur_idx() != 5; k++) tick_cyc(1'b0);
      reset = 1'b1;
      tick_cyc(1'b0);
      reset = 1'b0;
      run(40);

      for (int k = 0; k < 800; k++) begin
         value    = $urandom;
         dp_in    = 8'($urandom);
         blank_lz = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
         reset    = ($urandom_range(0, 199) == 0);
         tick_cyc(1'($urandom_range(0, 9) == 0));
      end
      reset = 1'b0;
      run(5);

      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
